// File: rtl/mips_timer_slave.sv
// Memory-mapped countdown timer on the CPU data bus. Four word registers
// (CTRL, PRESET, COUNT, reserved) and one interrupt line for the HWInt vector.

module mips_timer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  localparam logic [1:0] OffCtrl   = 2'd0;
  localparam logic [1:0] OffPreset = 2'd1;
  localparam logic [1:0] OffCount  = 2'd2;
  localparam logic [1:0] OffRsvd   = 2'd3;

  localparam logic [1:0] ModeReload = 2'b01;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;

  // The bus only issues word accesses, so the byte offset is never decoded.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign ctrl_en   = ctrl_q[0];
  assign ctrl_mode = ctrl_q[2:1];
  assign ctrl_im   = ctrl_q[3];

  // Bus decode: only full-word writes are accepted.
  always_comb begin
    sel       = (addr[31:4] == BASE_ADDR[31:4]);
    wr        = sel && (byteen == 4'b1111);
    wr_ctrl   = wr && (addr[3:2] == OffCtrl);
    wr_preset = wr && (addr[3:2] == OffPreset);
  end

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      ctrl_q     <= 4'b0000;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_en) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else if (count_q <= 32'd1) begin
          state_d = StInt;
        end
      end
      StInt: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register updates: FSM actions first, then CPU writes take priority.
  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      StIdle: begin
      end
      StLoad: begin
        count_d = preset_q;
      end
      StCnt: begin
        // A PRESET of 0 lands here with COUNT=0 and terminates like COUNT=1.
        if (ctrl_en) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = 32'h0;
            irq_flag_d = 1'b1;
          end
        end
      end
      StInt: begin
        if (ctrl_mode == ModeReload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end
      default: begin
      end
    endcase

    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
    end
    if (wr_preset) begin
      preset_d = wdata;
    end
    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
    end
  end

  // Zero-wait-state read mux.
  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      unique case (addr[3:2])
        OffCtrl:   rdata = {28'h0, ctrl_q};
        OffPreset: rdata = preset_q;
        OffCount:  rdata = count_q;
        OffRsvd:   rdata = 32'h0;
        default:   rdata = 32'h0;
      endcase
    end
  end

  assign irq = irq_flag_q && ctrl_im;

endmodule

// File: tb/tb_mips_timer_slave.sv
// Scoreboard bench for mips_timer_slave: each read pushes its expected rdata/irq,
// and a negedge monitor pops and compares against the DUT.

module tb_mips_timer_slave;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;
  localparam logic [31:0] A_RSV  = BASE + 32'd12;
  localparam logic [31:0] A_OUT  = BASE + 32'd16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  mips_timer_slave #(
    .BASE_ADDR(BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".rdata"}, rdata, e.data);
      check({e.tag, ".irq"}, {31'h0, irq}, {31'h0, e.irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    addr   = a;
    wdata  = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'h0;
    wdata  = 32'h0;
  endtask

  // Samples the state left by the most recent rising edge.
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_irq);
    exp_t e;
    addr   = a;
    byteen = 4'h0;
    e.tag  = tag;
    e.data = exp;
    e.irq  = exp_irq;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt5[8];
    int pat[6];
    cnt5 = '{0, 0, 5, 4, 3, 2, 1, 0};
    pat  = '{3, 2, 1, 0, 0, 0};

    reset  = 1'b0;
    addr   = 32'h0;
    byteen = 4'h0;
    wdata  = 32'h0;
    tick();
    tick();
    rd("rst.ctrl", A_CTRL, 32'h0, 1'b0);
    rd("rst.pre",  A_PRE,  32'h0, 1'b0);
    rd("rst.cnt",  A_CNT,  32'h0, 1'b0);
    rd("rst.rsv",  A_RSV,  32'h0, 1'b0);
    reset = 1'b1;

    // One-shot with interrupt enabled: EN written at edge k.
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int j = 0; j < 8; j++) begin
      rd($sformatf("os.cnt%0d", j), A_CNT, cnt5[j], j == 7);
    end
    rd("os.ctrl_k8", A_CTRL, 32'h8, 1'b1);
    rd("os.ctrl_k9", A_CTRL, 32'h8, 1'b1);
    wr(A_PRE, 32'd5);
    rd("os.irq_clr", A_PRE, 32'd5, 1'b0);

    // Auto-reload: single-cycle irq pulse every PRESET+3 cycles.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    rd("ar.cnt0", A_CNT, 32'h0, 1'b0);
    rd("ar.cnt1", A_CNT, 32'h0, 1'b0);
    for (int j = 2; j < 14; j++) begin
      rd($sformatf("ar.cnt%0d", j), A_CNT, pat[(j - 2) % 6], ((j - 2) % 6) == 3);
    end
    // Disabled while in LOAD: COUNT is loaded, then frozen in CNT.
    wr(A_CTRL, 32'h0);
    tick();
    rd("ar.frozen", A_CNT, 32'd3, 1'b0);

    // IM=0: flag sets but irq stays low; a CTRL write then clears the flag.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    tick();
    tick();
    rd("im0.cnt2", A_CNT, 32'd2, 1'b0);
    rd("im0.cnt1", A_CNT, 32'd1, 1'b0);
    rd("im0.cnt0", A_CNT, 32'd0, 1'b0);
    rd("im0.ctrl", A_CTRL, 32'h0, 1'b0);
    wr(A_CTRL, 32'h8);
    rd("im0.im_on", A_CTRL, 32'h8, 1'b0);

    // Bus decode.
    wr(A_PRE, 32'hDEAD_BEEF, 4'b0011);
    rd("dec.partial", A_PRE, 32'd2, 1'b0);
    wr(A_CTRL, 32'h1, 4'b1110);
    rd("dec.partial_ctrl", A_CTRL, 32'h8, 1'b0);
    wr(A_CNT, 32'd77);
    rd("dec.cnt_wr", A_CNT, 32'h0, 1'b0);
    wr(A_RSV, 32'd55);
    rd("dec.rsv_wr", A_RSV, 32'h0, 1'b0);
    wr(A_OUT + 32'd4, 32'd99);
    rd("dec.outside", A_OUT + 32'd4, 32'h0, 1'b0);
    rd("dec.pre_kept", A_PRE, 32'd2, 1'b0);

    // Mid-count disable, re-enable reloads, then reset during CNT.
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    repeat (5) tick();
    rd("mid.cnt7", A_CNT, 32'd7, 1'b0);
    wr(A_CTRL, 32'h0);
    rd("mid.hold0", A_CNT, 32'd6, 1'b0);
    rd("mid.hold1", A_CNT, 32'd6, 1'b0);
    rd("mid.hold2", A_CNT, 32'd6, 1'b0);
    wr(A_CTRL, 32'h1);
    rd("re.idle", A_CNT, 32'd6, 1'b0);
    rd("re.load", A_CNT, 32'd6, 1'b0);
    rd("re.cnt10", A_CNT, 32'd10, 1'b0);
    rd("re.cnt9", A_CNT, 32'd9, 1'b0);
    reset = 1'b0;
    tick();
    rd("mrst.ctrl", A_CTRL, 32'h0, 1'b0);
    rd("mrst.pre", A_PRE, 32'h0, 1'b0);
    rd("mrst.cnt", A_CNT, 32'h0, 1'b0);
    reset = 1'b1;

    // Reset drops a pending irq at the reset edge.
    wr(A_PRE, 32'd1);
    wr(A_CTRL, 32'h9);
    repeat (3) tick();
    rd("rirq.before", A_CNT, 32'h0, 1'b1);
    reset = 1'b0;
    tick();
    rd("rirq.after", A_CTRL, 32'h0, 1'b0);
    reset = 1'b1;
    tick();

    check("sb.empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_timer_slave.md
Name: mips_timer_slave

Overview:
- Memory-mapped countdown timer.
- Acts as a responder on the CPU data bus: m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata.
- Drives one bit of the CPU HWInt[5:0] vector.
- Sits beside DM behind the system bridge and answers word accesses in its 16-byte window.
- When enabled, it loads PRESET into COUNT, counts down once per clock, and raises an interrupt at terminal count.

Parameters:
- BASE_ADDR, 32'h0000_7F00, window base; must be 16-byte aligned. Decode is addr[31:4]==BASE_ADDR[31:4].

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset: sampled on clk rising edge, asserted when 0.
- addr  in  32  data-bus byte address (CPU M-stage m_data_addr).
- byteen  in  4  data-bus byte enables; any nonzero value = write request.
- wdata  in  32  data-bus write data.
- rdata  out  32  read data, combinational from addr.
- irq  out  1  interrupt request to HWInt bit.

Behaviour:
- Register map, by addr[3:2]:
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 read 0.
  - 1 PRESET: 32-bit.
  - 2 COUNT: read-only.
  - 3: reads 0, writes ignored.
- Select: sel = (addr[31:4]==BASE_ADDR[31:4]).
- Write: wr = sel && byteen==4'b1111.
  - Partial-byte writes (byteen nonzero, not 1111) are ignored.
  - Writes to COUNT or offset 3 are ignored.
  - CTRL write stores wdata[3:0] only.
- Read: rdata = selected register when sel, else 32'h0. Zero wait states; the CPU samples rdata in the same cycle.
- Reset (reset==0 at edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. irq=0 and rdata=0 for any register read.
- FSM states and transitions, one per clock edge:
  - IDLE: if EN → LOAD; else stay.
  - LOAD: COUNT<=PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds;
    - else if COUNT>1 → COUNT<=COUNT-1;
    - else (COUNT is 1 or 0) → COUNT<=0, irq_flag<=1, → INT.
  - INT:
    - MODE==0 (one-shot): EN<=0, → IDLE; irq_flag stays 1.
    - MODE==1 (auto-reload): irq_flag<=0, → IDLE. EN remains set, so it reloads.
    - MODE 2/3: behave as MODE 0.
- irq = irq_flag && CTRL.IM; purely combinational.
- irq_flag clear:
  - Any accepted write to CTRL or PRESET clears irq_flag at that edge.
  - In MODE 1, irq_flag clears automatically in INT, so irq is high for exactly 1 cycle.
- Latency: with EN written at edge k and PRESET=N≥1:
  - LOAD at k+1;
  - COUNT=N at k+2;
  - COUNT=0 and irq_flag=1 at edge k+N+2.
  - MODE 1 period = N+3 cycles between irq pulses.
- PRESET=0 behaves as PRESET=1: INT entered one edge after LOAD.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle the FSM clears EN (INT, mode 0) takes the written value.
  - A CPU clear of irq_flag wins over an FSM set in the same cycle.
  - A PRESET write during CNT does not alter COUNT until the next LOAD.
- Clearing EN mid-count freezes COUNT; re-enabling goes IDLE→LOAD, reloading PRESET (no resume).
- reset asserted mid-count: all state returns to reset values at that edge; irq drops the same edge.

Test Plan:
- Reset with reset=0 for 2 cycles → rdata 0 at all 4 offsets, irq=0.
- Write PRESET=5, then CTRL=4'b1001 (IM, mode 0, EN) at edge k → COUNT reads 5,4,3,2,1,0 on edges k+2..k+7. irq=1 from k+7 and stays. CTRL reads 4'b1000 after k+8. A PRESET write then drops irq.
- Mode 1: PRESET=3, CTRL=4'b1011 → irq single-cycle pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
- IM=0, mode 0, PRESET=2 → irq stays 0 while irq_flag sets. Writing CTRL=4'b1000 afterwards still gives irq=0, because the write clears the flag.
- Bus decode:
  - byteen=4'b0011 write to PRESET → unchanged.
  - Write to COUNT → ignored.
  - Address BASE_ADDR+16 → rdata 0, no register change.
- Mid-count disable/reset:
  - PRESET=10; clear EN when COUNT=6 → COUNT stays 6.
  - Re-enable → COUNT reloads 10.
  - Assert reset during CNT → all registers 0 at next edge.
